// File: rtl/wbs_scratch_mem.sv
// wbs_scratch_mem: Wishbone classic slave scratch memory with programmable
// wait states and a registered one-cycle acknowledge.
// Optional feature macro: WBS_MEM_ERR_EN (adds wb_err_o; out-of-range
// accesses then terminate with an error pulse instead of an ack).
module wbs_scratch_mem #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned MEM_AW      = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  output logic                  wb_ack_o
`ifdef WBS_MEM_ERR_EN
  ,
  output logic                  wb_err_o
`endif
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned DEPTH = 1 << MEM_AW;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic                    we_q, we_d;
  logic [DATA_WIDTH-1:0]   wdat_q, wdat_d;
  logic [DATA_WIDTH-1:0]   rdat_q;
  logic                    ack_q;
`ifdef WBS_MEM_ERR_EN
  logic                    err_q;
`endif

  // Access performed on the edge that enters ACK (from inputs or latched copy)
  logic                    fire_c;
  logic [ADDR_WIDTH-1:0]   f_adr_c;
  logic                    f_we_c;
  logic [DATA_WIDTH-1:0]   f_dat_c;
  logic                    in_range_c;
  logic [MEM_AW-1:0]       idx_c;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // Next-state logic: request capture, wait countdown, abort and ack entry
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    we_d    = we_q;
    wdat_d  = wdat_q;
    fire_c  = 1'b0;
    f_adr_c = adr_q;
    f_we_c  = we_q;
    f_dat_c = wdat_q;
    case (state_q)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          adr_d   = wb_adr_i;
          we_d    = wb_we_i;
          wdat_d  = wb_dat_i;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          f_adr_c = wb_adr_i;
          f_we_c  = wb_we_i;
          f_dat_c = wb_dat_i;
          if (WAIT_CYCLES == 0) begin
            state_d = ACK;
            fire_c  = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!wb_cyc_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q <= CNT_W'(1)) begin
          state_d = ACK;
          cnt_d   = '0;
          fire_c  = 1'b1;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign in_range_c = (32'(f_adr_c) < DEPTH);
  assign idx_c      = f_adr_c[MEM_AW-1:0];

  // State, latched request and registered bus outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      we_q    <= 1'b0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      ack_q   <= 1'b0;
`ifdef WBS_MEM_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      wdat_q  <= wdat_d;
`ifdef WBS_MEM_ERR_EN
      ack_q   <= fire_c & in_range_c;
      err_q   <= fire_c & ~in_range_c;
      if (fire_c && !f_we_c && in_range_c) rdat_q <= mem[idx_c];
`else
      ack_q   <= fire_c;
      if (fire_c && !f_we_c) rdat_q <= in_range_c ? mem[idx_c] : '0;
`endif
    end
  end

  // Storage array, deliberately not reset; writes only while out of reset
  always_ff @(posedge clk) begin
    if (rst && fire_c && f_we_c && in_range_c) mem[idx_c] <= f_dat_c;
  end

  assign wb_dat_o = rdat_q;
  assign wb_ack_o = ack_q;
`ifdef WBS_MEM_ERR_EN
  assign wb_err_o = err_q;
`endif

endmodule

// File: tb/tb_wbs_scratch_mem.sv
// Bench for wbs_scratch_mem: one instance with 2 wait states, one with none.
module tb_wbs_scratch_mem;

`ifdef WBS_MEM_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        we;
  logic [15:0] adr;
  logic [31:0] dat;
  logic        cyc0, stb0, cyc1, stb1;
  logic [31:0] dato0, dato1;
  logic        ack0, ack1, err0, err1;

  int nchk = 0;
  int nerr = 0;

  wbs_scratch_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .MEM_AW(8), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .rst(rst), .wb_cyc_i(cyc0), .wb_stb_i(stb0), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(dat), .wb_dat_o(dato0), .wb_ack_o(ack0)
`ifdef WBS_MEM_ERR_EN
    , .wb_err_o(err0)
`endif
  );

  wbs_scratch_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .MEM_AW(8), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .wb_cyc_i(cyc1), .wb_stb_i(stb1), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(dat), .wb_dat_o(dato1), .wb_ack_o(ack1)
`ifdef WBS_MEM_ERR_EN
    , .wb_err_o(err1)
`endif
  );

`ifndef WBS_MEM_ERR_EN
  assign err0 = 1'b0;
  assign err1 = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          z;
    bit          we;
    logic [15:0] adr;
    logic [31:0] dat;
    int          lat;
    bit          ack;
    bit          err;
    logic [31:0] rd;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(bit z, bit w, logic [15:0] a, logic [31:0] d,
                              int l, bit ak, bit er, logic [31:0] r);
    vec_t v;
    v.z = z; v.we = w; v.adr = a; v.dat = d; v.lat = l; v.ack = ak; v.err = er; v.rd = r;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic set_req(input bit z, input logic v);
    if (z) begin cyc1 = v; stb1 = v; end
    else   begin cyc0 = v; stb0 = v; end
  endtask

  // One bus transaction; lat = edge index (1 = sampling edge) where ack/err seen
  task automatic xact(input bit z, input bit w, input logic [15:0] a, input logic [31:0] d,
                      output int lat, output logic [31:0] rd, output bit ak, output bit er);
    lat = 0; ak = 1'b0; er = 1'b0; rd = '0;
    @(posedge clk); #1;
    we = w; adr = a; dat = d;
    set_req(z, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if ((z ? ack1 : ack0) || (z ? err1 : err0)) begin
        lat = k;
        ak  = z ? ack1 : ack0;
        er  = z ? err1 : err0;
        rd  = z ? dato1 : dato0;
        break;
      end
    end
    set_req(z, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] rd;
    bit          ak, er;

    rst = 1'b0; we = 1'b0; adr = '0; dat = '0;
    cyc0 = 1'b0; stb0 = 1'b0; cyc1 = 1'b0; stb1 = 1'b0;

    // Directed vectors: {dut, we, adr, dat, latency, ack, err, dat_o}
    vt.push_back(mk(1'b0, 1'b1, 16'h0010, 32'hDEADBEEF, 3, 1'b1, 1'b0, 32'h0));
    vt.push_back(mk(1'b0, 1'b0, 16'h0010, 32'h0,        3, 1'b1, 1'b0, 32'hDEADBEEF));
    vt.push_back(mk(1'b0, 1'b1, 16'h0000, 32'h0BADF00D, 3, 1'b1, 1'b0, 32'hDEADBEEF));
    vt.push_back(mk(1'b0, 1'b1, 16'h0011, 32'hA5A5A5A5, 3, 1'b1, 1'b0, 32'hDEADBEEF));
    vt.push_back(mk(1'b0, 1'b0, 16'h0011, 32'h0,        3, 1'b1, 1'b0, 32'hA5A5A5A5));
    vt.push_back(mk(1'b0, 1'b1, 16'h0100, 32'h11111111, 3, !ERR, ERR,  32'hA5A5A5A5));
    vt.push_back(mk(1'b0, 1'b0, 16'h0100, 32'h0,        3, !ERR, ERR,  ERR ? 32'hA5A5A5A5 : 32'h0));
    vt.push_back(mk(1'b0, 1'b0, 16'hFFFF, 32'h0,        3, !ERR, ERR,  ERR ? 32'hA5A5A5A5 : 32'h0));
    vt.push_back(mk(1'b0, 1'b0, 16'h0000, 32'h0,        3, 1'b1, 1'b0, 32'h0BADF00D));
    vt.push_back(mk(1'b0, 1'b1, 16'h0020, 32'hDEADBEEF, 3, 1'b1, 1'b0, 32'h0BADF00D));
    vt.push_back(mk(1'b1, 1'b1, 16'h0000, 32'h12345678, 1, 1'b1, 1'b0, 32'h0));
    vt.push_back(mk(1'b1, 1'b0, 16'h0000, 32'h0,        1, 1'b1, 1'b0, 32'h12345678));
    vt.push_back(mk(1'b1, 1'b1, 16'h00FF, 32'hFFFF0000, 1, 1'b1, 1'b0, 32'h12345678));
    vt.push_back(mk(1'b1, 1'b0, 16'h00FF, 32'h0,        1, 1'b1, 1'b0, 32'hFFFF0000));

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst ack0", 32'(ack0), 32'h0);
    chk("rst err0", 32'(err0), 32'h0);
    chk("rst dat0", dato0, 32'h0);
    chk("rst ack1", 32'(ack1), 32'h0);
    chk("rst dat1", dato1, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Table-driven transactions
    for (int i = 0; i < vt.size(); i++) begin
      xact(vt[i].z, vt[i].we, vt[i].adr, vt[i].dat, lat, rd, ak, er);
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vt[i].lat));
      chk($sformatf("vec%0d ack", i), 32'(ak), 32'(vt[i].ack));
      chk($sformatf("vec%0d err", i), 32'(er), 32'(vt[i].err));
      chk($sformatf("vec%0d dat_o", i), rd, vt[i].rd);
      @(posedge clk); #1;
      chk($sformatf("vec%0d ack drop", i), 32'({vt[i].z ? ack1 : ack0, vt[i].z ? err1 : err0}), 32'h0);
    end

    // Zero-wait, strobe held: acks on every other cycle only
    @(posedge clk); #1;
    we = 1'b0; adr = 16'h0000;
    set_req(1'b1, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      chk($sformatf("b2b ack k%0d", k), 32'(ack1), 32'(k % 2));
      if (k % 2 == 1) chk($sformatf("b2b dat k%0d", k), dato1, 32'h12345678);
    end
    set_req(1'b1, 1'b0);
    @(posedge clk); #1;

    // Abort: drop cyc during WAIT, write must not land
    @(posedge clk); #1;
    we = 1'b1; adr = 16'h0020; dat = 32'hCAFEF00D;
    set_req(1'b0, 1'b1);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("abort no ack c%0d", k), 32'(ack0), 32'h0);
    end
    xact(1'b0, 1'b0, 16'h0020, 32'h0, lat, rd, ak, er);
    chk("abort readback lat", 32'(lat), 32'd3);
    chk("abort readback dat", rd, 32'hDEADBEEF);

    // Reset during WAIT of a write
    @(posedge clk); #1;
    we = 1'b1; adr = 16'h0010; dat = 32'h55555555;
    set_req(1'b0, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midrst ack0", 32'(ack0), 32'h0);
    chk("midrst dat0", dato0, 32'h0);
    chk("midrst dat1", dato1, 32'h0);
    set_req(1'b0, 1'b0);
    @(posedge clk); #1;
    chk("midrst hold ack0", 32'(ack0), 32'h0);
    rst = 1'b1;
    xact(1'b0, 1'b0, 16'h0010, 32'h0, lat, rd, ak, er);
    chk("postrst lat", 32'(lat), 32'd3);
    chk("postrst dat", rd, 32'hDEADBEEF);
    xact(1'b1, 1'b0, 16'h0000, 32'h0, lat, rd, ak, er);
    chk("postrst w0 lat", 32'(lat), 32'd1);
    chk("postrst w0 dat", rd, 32'h12345678);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/wbs_scratch_mem.md
# wbs_scratch_mem

Wishbone classic slave that terminates the bus cycles issued by `uart_wbs_bridge`: a word-addressed scratch memory with a programmable wait-state counter and a registered acknowledge. It sits directly downstream of the bridge's `wb_*` master port. The bridge's UART host can then write and read back memory contents, and bench and silicon bring-up exercise real slave latency instead of a combinational model.

## Interface
Parameters:
- `DATA_WIDTH`, 32, data bus width in bits.
- `ADDR_WIDTH`, 16, Wishbone word address width; matches the bridge.
- `MEM_AW`, 8, log2 of memory depth in words (DEPTH = 2^MEM_AW).
- `WAIT_CYCLES`, 2, extra cycles inserted before acknowledge (0..15).

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `wb_cyc_i`  in  1  bus cycle valid.
- `wb_stb_i`  in  1  strobe.
- `wb_we_i`  in  1  1 = write, 0 = read.
- `wb_adr_i`  in  ADDR_WIDTH  word address.
- `wb_dat_i`  in  DATA_WIDTH  write data.
- `wb_dat_o`  out  DATA_WIDTH  read data; registered.
- `wb_ack_o`  out  1  acknowledge; one-cycle pulse.
- `wb_err_o`  out  1  error termination; present only with `WBS_MEM_ERR_EN`.

## Operation
- FSM states: IDLE, WAIT, ACK.
- **IDLE**
  - On `wb_cyc_i & wb_stb_i`, latch `adr`, `we` and `dat_i`. Load the counter with WAIT_CYCLES.
  - Go to WAIT if WAIT_CYCLES > 0, else to ACK.
- **WAIT**
  - Decrement the counter each cycle.
  - When the counter reaches 1, go to ACK.
  - If `wb_cyc_i` drops, go to IDLE with no write and no ack (abort).
- **ACK**
  - Assert `wb_ack_o` (or `wb_err_o`) for exactly one cycle.
  - Writes commit to the array on this edge.
  - Reads load `wb_dat_o` in the same cycle.
  - Always return to IDLE next. If `cyc & stb` is still high in IDLE, it is treated as a new transaction.
- **In range**: `adr < DEPTH`. The index is `adr[MEM_AW-1:0]`.
- **Out of range**:
  - Writes are dropped.
  - Reads return 0.
  - The cycle terminates per Configuration.
- The memory array is not reset; contents are undefined until written.
- `wb_dat_o` holds its last read value until the next read ack. Writes do not change it.

## Timing
- Reset values (asserted low, asynchronous): state = IDLE, counter = 0, `wb_ack_o` = 0, `wb_err_o` = 0, `wb_dat_o` = 0.
- Latency: request sampled at edge N ⇒ `wb_ack_o` high in the cycle after edge N+WAIT_CYCLES. Minimum is 1 cycle (WAIT_CYCLES = 0).
- Back-to-back requests: a new request is accepted no earlier than the edge after the ack cycle. There are never two consecutive ack cycles.
- Input changes after sampling in IDLE are ignored until the next IDLE; only `wb_cyc_i` is monitored, for abort.
- Reset mid-WAIT or mid-ACK:
  - Outputs clear immediately.
  - A pending write is discarded.
  - The array keeps prior contents.
- `wb_cyc_i` dropping in the ACK cycle: the ack still pulses and the write still commits.

## Configuration
- Macro `WBS_MEM_ERR_EN`.
- **Defined:**
  - `wb_err_o` port exists.
  - Out-of-range accesses terminate with `wb_err_o` = 1 for one cycle instead of `wb_ack_o`.
  - `wb_dat_o` is unchanged on error.
- **Undefined:**
  - No `wb_err_o` port.
  - Out-of-range accesses terminate with a normal `wb_ack_o`, with read data 0.

## Test plan
- **Write then read back:** write 0xDEADBEEF to adr 0x0010, WAIT_CYCLES = 2 ⇒ ack exactly 3 cycles after stb sampled. Read of 0x0010 ⇒ `wb_dat_o` = 0xDEADBEEF in the ack cycle.
- **Zero wait:** WAIT_CYCLES = 0, read adr 0x0000 after writing 0x12345678 ⇒ ack in the first cycle after sampling, data 0x12345678. stb held high across ack ⇒ second ack 2 cycles later, never adjacent.
- **Abort:** write 0xCAFEF00D to adr 0x0020, drop `wb_cyc_i` during WAIT ⇒ no ack. A later read of 0x0020 returns the prior value 0xDEADBEEF-seeded, not 0xCAFEF00D.
- **Out of range, macro undefined:** write to 0x0100 (MEM_AW = 8) ⇒ ack and no array change; read 0x0100 ⇒ ack with data 0x00000000.
- **Out of range, macro defined:** read 0x0100 ⇒ `wb_err_o` pulses 1 cycle, `wb_ack_o` stays 0, `wb_dat_o` unchanged.
- **Reset mid-transaction:** assert `rst` low during WAIT of a write ⇒ ack/dat_o go 0 asynchronously, state IDLE. The address reads back its old value after release.
